pkt_input_parser: RTL and testbench
===================================

# pkt_input_parser

Byte-stream packet parser between the host input FIFO and `template_list`. It reads packets one byte per cycle and validates each 16-byte header. It forwards the data bytes of word-list and template-list packets into `template_list` through its `din` / `wr_en` / `full` / `inpkt_end` / `is_template_list` port set, then verifies the trailing 32-bit data checksum. Any protocol violation sets a sticky error flag and halts input until reset.

## Interface
Parameters:
- `VERSION`, 2: required packet version byte.
- `PKT_TYPE_WORD_LIST`, 1: type code forwarded with `is_template_list`=0.
- `PKT_TYPE_TEMPLATE_LIST`, 4: type code forwarded with `is_template_list`=1.
- `PKT_MAX_LEN`, 65536: maximum data length in bytes. Lengths 1..`PKT_MAX_LEN` are legal.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  8  byte from first-word-fall-through input FIFO.
- `din_empty`  in  1  input FIFO empty.
- `din_rd_en`  out  1  combinational pop; a byte transfers when `din_rd_en`=1.
- `dout`  out  8  data byte to `template_list`.
- `wr_en`  out  1  combinational: `out_valid & ~full`.
- `full`  in  1  `template_list` full.
- `inpkt_end`  out  1  qualifies `dout`; marks the packet's last data byte.
- `is_template_list`  out  1  type of the current packet; held from end of header to next header end.
- `pkt_id`  out  16  id of the current packet; registered at end of header.
- `err_pkt_version`, `err_pkt_type`, `err_pkt_len`, `err_pkt_checksum`  out  1 each  sticky error flags.

## Operation
- Header byte map:
  - b0: version; b1: type; b2–3: reserved.
  - b4–6: data length, 24-bit little-endian; b7: reserved.
  - b8–9: id, little-endian; b10–11: reserved.
  - b12–15: header checksum = ~(w0+w1+w2) mod 2^32, where w0..w2 are the little-endian 32-bit words of b0–11.
- Data: `len` bytes. Trailer: 4 bytes, data checksum = ~(sum of little-endian 32-bit words of data) mod 2^32. A partial final word is zero-padded in its high bytes.
- States:
  - HDR: 4-bit byte counter; `din_rd_en` = `~din_empty`. Accumulates the checksum and captures fields.
  - On the 16th byte, checks in this priority: version, type, length, checksum. The first failure sets its flag and goes to ERROR. Otherwise loads `is_template_list` and `pkt_id`, clears the data accumulator, and goes to DATA.
  - DATA: `din_rd_en` = `~din_empty & (~out_valid | ~full)`. Each byte is loaded into the output register with `out_valid`=1; `inpkt_end` is set when the remaining count is 1. A 24-bit down-counter and a 2-bit byte lane accumulate the checksum. The last byte goes to CSUM.
  - CSUM: reads 4 bytes, as in HDR. A mismatch sets `err_pkt_checksum` and goes to ERROR; otherwise returns to HDR.
  - ERROR: terminal. `din_rd_en`=0. An already-loaded output byte still drains.
- Output register: `out_valid` clears when `wr_en` fires and no new byte loads. Load and drain may occur in the same cycle.
- Data is forwarded before checksum verification. A data-checksum error only flags; forwarded bytes are not recalled.
- Reserved bytes are ignored; they are not checked.

## Timing
- Reset values: `dout`=0, `out_valid`=0, `wr_en`=0, `inpkt_end`=0, `is_template_list`=0, `pkt_id`=0, all errors 0, state HDR, all counters 0. `din_rd_en`=0 while `rst_n`=0.
- Throughput: 1 byte/cycle. A packet of length L with no stalls takes 16+L+4 cycles. HDR and CSUM are never stalled by `full`.
- Latency: byte popped in cycle n appears on `dout` in cycle n+1. `wr_en` in cycle n+1 if `full`=0.
- `full` rising in the same cycle as a pending `out_valid`: no `wr_en`. The byte holds until `full` falls, and `din_rd_en` stays 0 meanwhile.
- `din_empty` mid-packet: the state machine pauses; no counter advances.
- Back-to-back packets: the first header byte may be popped in the cycle after the last trailer byte.
- Reset asserted mid-packet: immediately aborts. The held byte is dropped and `wr_en` falls asynchronously. After reset the parser expects a header, so it will misparse if the FIFO is not also flushed.
- Length: 24-bit compare; `len`=0 or `len`>`PKT_MAX_LEN` sets `err_pkt_len`.

## Test plan
- Word-list packet: version 2, type 1, id 0x1234, len 4, data "ab\0c", correct checksums. Required response:
  - `dout` sequence 0x61, 0x62, 0x00, 0x63 with `wr_en`.
  - `inpkt_end` only on 0x63; `is_template_list`=0; `pkt_id`=0x1234; no errors.
- Template-list packet, len 3, data 0x61, 0x00, 0x81, with `full` held high for 5 cycles after the 2nd byte. Required response:
  - 3rd byte delivered once, after `full` falls, with `inpkt_end`=1 and `is_template_list`=1.
  - No byte duplicated or lost.
- Header with version 3 → `err_pkt_version`=1 after byte 16. `wr_en` never asserts and `din_rd_en` stays 0 thereafter.
- Header with len=0, and separately with type 7:
  - len=0 → `err_pkt_len`.
  - type 7 → `err_pkt_type`.
  - Both are raised only after the 16th byte, and no data is forwarded.
- Corrupted data checksum (bit 0 flipped), len 5: all 5 bytes are forwarded; `err_pkt_checksum`=1 on the cycle after the 4th trailer byte.
- Two packets back-to-back with `din_empty` toggling every 3 cycles, then `rst_n` pulsed low mid-DATA of a third packet:
  - First two packets delivered intact.
  - `wr_en`=0 during reset; all outputs at reset values.

Source files
------------

// File: rtl/pkt_input_parser.sv
`default_nettype none
// ============================================================================
// Module   : pkt_input_parser
// Desc     : Byte-stream packet parser. Validates a 16-byte header, forwards
//            word-list / template-list data bytes to template_list, and
//            verifies the trailing 32-bit data checksum. Protocol errors are
//            sticky and halt input until reset.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_input_parser #(
  parameter int VERSION                = 2,
  parameter int PKT_TYPE_WORD_LIST     = 1,
  parameter int PKT_TYPE_TEMPLATE_LIST = 4,
  parameter int PKT_MAX_LEN            = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_empty,
  output logic        din_rd_en,
  output logic [7:0]  dout,
  output logic        wr_en,
  input  logic        full,
  output logic        inpkt_end,
  output logic        is_template_list,
  output logic [15:0] pkt_id,
  output logic        err_pkt_version,
  output logic        err_pkt_type,
  output logic        err_pkt_len,
  output logic        err_pkt_checksum
);

  localparam logic [1:0]  c_st_hdr   = 2'd0;
  localparam logic [1:0]  c_st_data  = 2'd1;
  localparam logic [1:0]  c_st_csum  = 2'd2;
  localparam logic [1:0]  c_st_error = 2'd3;

  localparam logic [7:0]  c_version  = 8'(VERSION);
  localparam logic [7:0]  c_type_wl  = 8'(PKT_TYPE_WORD_LIST);
  localparam logic [7:0]  c_type_tl  = 8'(PKT_TYPE_TEMPLATE_LIST);
  localparam logic [23:0] c_max_len  = 24'(PKT_MAX_LEN);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [3:0]  r_hdr_cnt;     // header byte index; low 2 bits reused as trailer index
  logic [7:0]  r_ver;
  logic [7:0]  r_type;
  logic [23:0] r_len;
  logic [15:0] r_id;
  logic [23:0] r_rx;          // first three bytes of a received checksum
  logic [31:0] r_hsum;
  logic [31:0] r_dsum;
  logic [23:0] r_remain;
  logic [1:0]  r_lane;
  logic [7:0]  r_dout;
  logic        r_out_valid;
  logic        r_inpkt_end;
  logic        r_is_tl;
  logic [15:0] r_pkt_id;
  logic        r_err_ver;
  logic        r_err_type;
  logic        r_err_len;
  logic        r_err_csum;

  logic [31:0] w_hdr_term;
  logic [31:0] w_data_term;
  logic [31:0] w_rx_word;
  logic        w_hdr_last;
  logic        w_csum_last;
  logic        w_data_last;
  logic        w_ver_bad;
  logic        w_type_bad;
  logic        w_len_bad;
  logic        w_hcsum_bad;
  logic        w_hdr_bad;
  logic        w_dcsum_bad;

  // Summing each byte at its lane position equals summing little-endian
  // words, with a short final word naturally zero-padded.
  assign w_hdr_term  = {24'd0, din} << {r_hdr_cnt[1:0], 3'b000};
  assign w_data_term = {24'd0, din} << {r_lane, 3'b000};
  assign w_rx_word   = {din, r_rx};

  assign w_hdr_last  = (r_hdr_cnt == 4'd15);
  assign w_csum_last = (r_hdr_cnt[1:0] == 2'd3);
  assign w_data_last = (r_remain == 24'd1);

  assign w_ver_bad   = (r_ver != c_version);
  assign w_type_bad  = (r_type != c_type_wl) && (r_type != c_type_tl);
  assign w_len_bad   = (r_len == 24'd0) || (r_len > c_max_len);
  assign w_hcsum_bad = (w_rx_word != ~r_hsum);
  assign w_hdr_bad   = w_ver_bad | w_type_bad | w_len_bad | w_hcsum_bad;
  assign w_dcsum_bad = (w_rx_word != ~r_dsum);

  assign dout             = r_dout;
  assign wr_en            = r_out_valid & ~full;
  assign inpkt_end        = r_inpkt_end;
  assign is_template_list = r_is_tl;
  assign pkt_id           = r_pkt_id;
  assign err_pkt_version  = r_err_ver;
  assign err_pkt_type     = r_err_type;
  assign err_pkt_len      = r_err_len;
  assign err_pkt_checksum = r_err_csum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_hdr;
    else        r_state <= w_next_state;
  end

  // Next-state logic: advance only on a popped byte
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_hdr:  if (din_rd_en && w_hdr_last)
                   w_next_state = w_hdr_bad ? c_st_error : c_st_data;
      c_st_data: if (din_rd_en && w_data_last)
                   w_next_state = c_st_csum;
      c_st_csum: if (din_rd_en && w_csum_last)
                   w_next_state = w_dcsum_bad ? c_st_error : c_st_hdr;
      default:   w_next_state = c_st_error;
    endcase
  end

  // Output logic: FIFO pop, held off in reset, in ERROR and by a blocked output byte
  always_comb begin
    din_rd_en = 1'b0;
    if (rst_n) begin
      case (r_state)
        c_st_hdr,
        c_st_csum: din_rd_en = ~din_empty;
        c_st_data: din_rd_en = ~din_empty & (~r_out_valid | ~full);
        default:   din_rd_en = 1'b0;
      endcase
    end
  end

  // Header/trailer parsing, checksum accumulation and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_cnt  <= 4'd0;
      r_ver      <= 8'd0;
      r_type     <= 8'd0;
      r_len      <= 24'd0;
      r_id       <= 16'd0;
      r_rx       <= 24'd0;
      r_hsum     <= 32'd0;
      r_dsum     <= 32'd0;
      r_remain   <= 24'd0;
      r_lane     <= 2'd0;
      r_is_tl    <= 1'b0;
      r_pkt_id   <= 16'd0;
      r_err_ver  <= 1'b0;
      r_err_type <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_csum <= 1'b0;
    end else if (din_rd_en) begin
      case (r_state)
        c_st_hdr: begin
          r_hdr_cnt <= r_hdr_cnt + 4'd1;
          if (r_hdr_cnt < 4'd12) r_hsum <= r_hsum + w_hdr_term;
          case (r_hdr_cnt)
            4'd0:    r_ver        <= din;
            4'd1:    r_type       <= din;
            4'd4:    r_len[7:0]   <= din;
            4'd5:    r_len[15:8]  <= din;
            4'd6:    r_len[23:16] <= din;
            4'd8:    r_id[7:0]    <= din;
            4'd9:    r_id[15:8]   <= din;
            4'd12:   r_rx[7:0]    <= din;
            4'd13:   r_rx[15:8]   <= din;
            4'd14:   r_rx[23:16]  <= din;
            default: ;
          endcase
          if (w_hdr_last) begin
            r_hsum <= 32'd0;
            if (w_ver_bad)        r_err_ver  <= 1'b1;
            else if (w_type_bad)  r_err_type <= 1'b1;
            else if (w_len_bad)   r_err_len  <= 1'b1;
            else if (w_hcsum_bad) r_err_csum <= 1'b1;
            else begin
              r_is_tl  <= (r_type == c_type_tl);
              r_pkt_id <= r_id;
              r_remain <= r_len;
              r_lane   <= 2'd0;
              r_dsum   <= 32'd0;
            end
          end
        end
        c_st_data: begin
          r_remain <= r_remain - 24'd1;
          r_lane   <= r_lane + 2'd1;
          r_dsum   <= r_dsum + w_data_term;
        end
        c_st_csum: begin
          case (r_hdr_cnt[1:0])
            2'd0:    r_rx[7:0]   <= din;
            2'd1:    r_rx[15:8]  <= din;
            2'd2:    r_rx[23:16] <= din;
            default: ;
          endcase
          if (w_csum_last) begin
            r_hdr_cnt <= 4'd0;
            if (w_dcsum_bad) r_err_csum <= 1'b1;
          end else begin
            r_hdr_cnt <= r_hdr_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output holding register: a data pop loads it, otherwise an accepted byte drains it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout      <= 8'd0;
      r_out_valid <= 1'b0;
      r_inpkt_end <= 1'b0;
    end else if (r_state == c_st_data && din_rd_en) begin
      r_dout      <= din;
      r_out_valid <= 1'b1;
      r_inpkt_end <= w_data_last;
    end else if (wr_en) begin
      r_out_valid <= 1'b0;
      r_inpkt_end <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_input_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_input_parser
// Desc     : Self-checking bench for pkt_input_parser. Packets are built from
//            field values, forwarded bytes are predicted into a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_input_parser;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0]  b;
    logic        last;
    logic        tl;
    logic [15:0] id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_empty = 1'b1;
  logic        din_rd_en;
  logic [7:0]  dout;
  logic        wr_en;
  logic        full = 1'b0;
  logic        inpkt_end;
  logic        is_template_list;
  logic [15:0] pkt_id;
  logic        err_pkt_version, err_pkt_type, err_pkt_len, err_pkt_checksum;

  logic [7:0] fifo[$];
  exp_t       exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int pops     = 0;
  int wr_seen  = 0;
  bit pop_s    = 1'b0;
  bit stall_en = 1'b0;
  bit stall_ph = 1'b0;
  int stall_cnt = 0;
  int full_cnt  = 0;
  bit full_arm  = 1'b0;
  int full_at   = 0;

  pkt_input_parser dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .din              (din),
    .din_empty        (din_empty),
    .din_rd_en        (din_rd_en),
    .dout             (dout),
    .wr_en            (wr_en),
    .full             (full),
    .inpkt_end        (inpkt_end),
    .is_template_list (is_template_list),
    .pkt_id           (pkt_id),
    .err_pkt_version  (err_pkt_version),
    .err_pkt_type     (err_pkt_type),
    .err_pkt_len      (err_pkt_len),
    .err_pkt_checksum (err_pkt_checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] csum_of(input bq_t q);
    logic [31:0] s;
    logic [31:0] w;
    s = 32'd0;
    for (int i = 0; i < q.size(); i += 4) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++)
        if (i + k < q.size()) w[8*k +: 8] = q[i+k];
      s = s + w;
    end
    return ~s;
  endfunction

  function automatic logic [3:0] errs();
    return {err_pkt_version, err_pkt_type, err_pkt_len, err_pkt_checksum};
  endfunction

  task automatic drive_din();
    din       = (fifo.size() > 0) ? fifo[0] : 8'h00;
    din_empty = (fifo.size() == 0) || (stall_en && stall_ph);
  endtask

  task automatic build_pkt(input logic [7:0] ver, input logic [7:0] typ, input logic [23:0] len,
                           input logic [15:0] id, input logic [7:0] rsv, input bq_t data,
                           input bit bad, output bq_t pkt);
    bq_t h;
    logic [31:0] c;
    h = '{ver, typ, rsv, rsv, len[7:0], len[15:8], len[23:16], rsv,
          id[7:0], id[15:8], rsv, rsv};
    c = csum_of(h);
    pkt = h;
    for (int k = 0; k < 4; k++) pkt.push_back(c[8*k +: 8]);
    foreach (data[i]) pkt.push_back(data[i]);
    c = csum_of(data) ^ {31'd0, bad};
    for (int k = 0; k < 4; k++) pkt.push_back(c[8*k +: 8]);
  endtask

  task automatic send_pkt(input logic [7:0] ver, input logic [7:0] typ, input logic [23:0] len,
                          input logic [15:0] id, input logic [7:0] rsv, input bq_t data,
                          input bit bad, input bit fwd);
    bq_t  pkt;
    exp_t e;
    build_pkt(ver, typ, len, id, rsv, data, bad, pkt);
    foreach (pkt[i]) fifo.push_back(pkt[i]);
    if (fwd) begin
      foreach (data[i]) begin
        e.b    = data[i];
        e.last = (i == data.size() - 1);
        e.tl   = (typ == 8'd4);
        e.id   = id;
        exp_q.push_back(e);
      end
    end
    drive_din();
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (fifo.size() == 0 && exp_q.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    chk({name, "_all_delivered"}, exp_q.size(), 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #2 rst_n = 1'b0;
    fifo.delete();
    exp_q.delete();
    full_cnt = 0;
    full_arm = 1'b0;
    full     = 1'b0;
    stall_en = 1'b0;
    drive_din();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  // Feeder: retire popped byte, pace the FIFO and the full input
  always @(posedge clk) begin
    #1;
    if (pop_s && rst_n && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    stall_cnt++;
    if (stall_cnt == 3) begin
      stall_cnt = 0;
      stall_ph  = ~stall_ph;
    end
    if (full_arm && wr_seen >= full_at) begin
      full_arm = 1'b0;
      full_cnt = 5;
    end
    if (full_cnt > 0) begin
      full = 1'b1;
      full_cnt--;
    end else begin
      full = 1'b0;
    end
    drive_din();
  end

  // Compare process: every accepted byte against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    pop_s = din_rd_en;
    if (rst_n) begin
      if (wr_en) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          chk("wr_en_without_expected_byte", {31'd0, wr_en}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dout", {24'd0, dout}, {24'd0, e.b});
          chk("inpkt_end", {31'd0, inpkt_end}, {31'd0, e.last});
          chk("is_template_list", {31'd0, is_template_list}, {31'd0, e.tl});
          chk("pkt_id", {16'd0, pkt_id}, {16'd0, e.id});
        end
      end
      if (full) chk("wr_en_while_full", {31'd0, wr_en}, 32'd0);
    end
  end

  task automatic run_err(input string name, input logic [7:0] ver, input logic [7:0] typ,
                         input logic [23:0] len, input logic [3:0] exp_err);
    int  base;
    bit  seen15;
    bq_t d;
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    base   = pops;
    seen15 = 1'b0;
    send_pkt(ver, typ, len, 16'h0BAD, 8'h00, d, 1'b0, 1'b0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (pops - base == 15 && !seen15) begin
        seen15 = 1'b1;
        chk({name, "_no_err_before_byte16"}, {28'd0, errs()}, 32'd0);
      end
      if (pops - base >= 16) break;
    end
    chk({name, "_err_after_byte16"}, {28'd0, errs()}, {28'd0, exp_err});
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 7) chk({name, "_rd_en_low_after_err"}, {31'd0, din_rd_en}, 32'd0);
    end
    chk({name, "_pops_stop_at_16"}, pops - base, 16);
    reset_dut();
  endtask

  initial begin
    bq_t d, h;
    int  cyc;
    logic prev;

    // Reset state, with the FIFO offering a byte
    fifo.push_back(8'hAA);
    drive_din();
    repeat (3) @(negedge clk);
    chk("rst_din_rd_en", {31'd0, din_rd_en}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_inpkt_end", {31'd0, inpkt_end}, 32'd0);
    chk("rst_is_tl", {31'd0, is_template_list}, 32'd0);
    chk("rst_pkt_id", {16'd0, pkt_id}, 32'd0);
    chk("rst_errs", {28'd0, errs()}, 32'd0);
    reset_dut();

    // Model pins: hand-computed checksums of the word-list test packet
    h = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00};
    chk("pin_hdr_csum", csum_of(h), 32'hFFFFECC5);
    d = '{8'h61, 8'h62, 8'h00, 8'h63};
    chk("pin_data_csum", csum_of(d), 32'h9CFF9D9E);

    // Word-list packet, also measuring 16+L+4 cycle throughput
    @(posedge clk);
    #2 send_pkt(8'd2, 8'd1, 24'd4, 16'h1234, 8'h00, d, 1'b0, 1'b1);
    cyc = 0;
    while (fifo.size() != 0 && cyc < 200) begin
      @(posedge clk);
      #2 cyc++;
    end
    chk("wl_cycles", cyc, 24);
    wait_idle("wl");
    chk("wl_pkt_id", {16'd0, pkt_id}, 32'h1234);
    chk("wl_is_tl", {31'd0, is_template_list}, 32'd0);
    chk("wl_errs", {28'd0, errs()}, 32'd0);

    // Template-list packet with full held for 5 cycles after the 2nd byte
    d = '{8'h61, 8'h00, 8'h81};
    full_at  = wr_seen + 2;
    full_arm = 1'b1;
    send_pkt(8'd2, 8'd4, 24'd3, 16'h0042, 8'hE7, d, 1'b0, 1'b1);
    wait_idle("tl");
    chk("tl_is_tl", {31'd0, is_template_list}, 32'd1);
    chk("tl_pkt_id", {16'd0, pkt_id}, 32'h0042);
    chk("tl_errs", {28'd0, errs()}, 32'd0);

    // Corrupted data checksum, len 5
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_pkt(8'd2, 8'd1, 24'd5, 16'h0777, 8'h00, d, 1'b1, 1'b1);
    prev = err_pkt_checksum;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (fifo.size() == 0) break;
      prev = err_pkt_checksum;
    end
    chk("dcsum_err_before_last_trailer", {31'd0, prev}, 32'd0);
    chk("dcsum_err_after_last_trailer", {28'd0, errs()}, 32'd1);
    wait_idle("dcsum");
    reset_dut();

    // Header errors
    run_err("ver3",  8'd3, 8'd1, 24'd4, 4'b1000);
    run_err("len0",  8'd2, 8'd1, 24'd0, 4'b0010);
    run_err("type7", 8'd2, 8'd7, 24'd4, 4'b0100);
    run_err("lenmax1", 8'd2, 8'd1, 24'd65537, 4'b0010);

    // Back-to-back packets with a stalling FIFO, then reset mid-DATA of a third
    stall_en = 1'b1;
    d = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    send_pkt(8'd2, 8'd1, 24'd6, 16'h0101, 8'hEE, d, 1'b0, 1'b1);
    d = '{8'hF1, 8'hF2, 8'hF3};
    send_pkt(8'd2, 8'd4, 24'd3, 16'h0202, 8'h00, d, 1'b0, 1'b1);
    d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
    send_pkt(8'd2, 8'd1, 24'd8, 16'h0303, 8'h00, d, 1'b0, 1'b1);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (exp_q.size() <= 5) break;
    end
    chk("b2b_third_pkt_reached", exp_q.size(), 5);
    chk("b2b_errs", {28'd0, errs()}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_wr_en", {31'd0, wr_en}, 32'd0);
    fifo.delete();
    exp_q.delete();
    stall_en = 1'b0;
    drive_din();
    @(negedge clk);
    chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("midrst_dout", {24'd0, dout}, 32'd0);
    chk("midrst_inpkt_end", {31'd0, inpkt_end}, 32'd0);
    chk("midrst_is_tl", {31'd0, is_template_list}, 32'd0);
    chk("midrst_pkt_id", {16'd0, pkt_id}, 32'd0);
    chk("midrst_errs", {28'd0, errs()}, 32'd0);
    chk("midrst_rd_en", {31'd0, din_rd_en}, 32'd0);
    #2 rst_n = 1'b1;

    // Parser accepts a fresh header after reset
    d = '{8'h61, 8'h62, 8'h00, 8'h63};
    @(posedge clk);
    #2 send_pkt(8'd2, 8'd1, 24'd4, 16'h1234, 8'h00, d, 1'b0, 1'b1);
    wait_idle("post_rst");
    chk("post_rst_errs", {28'd0, errs()}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
